// File: rtl/sonar_echo_capture_pkg.sv
// Shared constants and FSM encoding for the sonar echo capture block.
package sonar_echo_capture_pkg;

    localparam int CLKS_PER_US_DEF = 50;
    localparam int TRIG_US_DEF     = 10;
    localparam int TIMEOUT_US_DEF  = 38000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sonar_echo_capture_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US clocks, restartable.
module us_tick_gen #(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0]   TERM = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sonar_echo_capture.sv
// Ultrasonic ranger front end: fires a trigger pulse, then times the echo high width in us.
module sonar_echo_capture
    import sonar_echo_capture_pkg::*;
#(
    parameter int CLKS_PER_US = CLKS_PER_US_DEF,
    parameter int TRIG_US     = TRIG_US_DEF,
    parameter int TIMEOUT_US  = TIMEOUT_US_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        echo_in,
    output logic        trig_out,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] width_us
);

    state_e      state_q, state_d;
    logic        sync1_q, echo_s_q, echo_prev_q;
    logic [31:0] us_q, us_d;
    logic [31:0] width_q, width_d;
    logic        tmo_q, tmo_d;
    logic        us_tick;
    logic        restart;

    // Every state change restarts both the prescaler and the per-state us count.
    assign restart = (state_d != state_q);

    us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (us_tick)
    );

    always_comb begin
        state_d = state_q;
        us_d    = us_tick ? us_q + 32'd1 : us_q;
        width_d = width_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TRIG;
                    width_d = '0;
                    tmo_d   = 1'b0;
                end
            end
            ST_TRIG: begin
                if (us_tick && us_q == 32'(TRIG_US - 1)) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                // prev must be low, so an echo already high on entry never qualifies
                if (echo_s_q && !echo_prev_q) begin
                    state_d = ST_MEASURE;
                end else if (us_tick && us_q == 32'(TIMEOUT_US - 1)) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                    width_d = '0;
                end
            end
            ST_MEASURE: begin
                if (us_tick) width_d = width_q + 32'd1;
                // falling edge beats a coincident saturation tick
                if (!echo_s_q) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b0;
                end else if (us_tick && width_q == 32'(TIMEOUT_US - 1)) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) us_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
            us_q        <= '0;
            width_q     <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= echo_in;
            echo_s_q    <= sync1_q;
            echo_prev_q <= echo_s_q;
            us_q        <= us_d;
            width_q     <= width_d;
            tmo_q       <= tmo_d;
        end
    end

    // Decoded straight from the async-reset state so trig drops the moment reset asserts.
    assign trig_out = (state_q == ST_TRIG);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign timeout  = tmo_q;
    assign width_us = width_q;

endmodule
